// File: rtl/johnson_ctrl_pkg.sv
// Shared types, default widths and the Johnson step function for the
// start/stop Johnson counter scheduler.
package johnson_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_LEN_WIDTH = 8;
  localparam int DEF_JC_WIDTH  = 8;
  localparam int JC_MAX        = 32;

  // Operates on a zero-extended register; bits at and above w are don't-care.
  function automatic logic [JC_MAX-1:0] jc_next(input logic [JC_MAX-1:0] jc, input int w);
    logic [JC_MAX-1:0] r;
    r    = jc << 1;
    r[0] = ~jc[w-1];
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request searching upward
// from (last+1) mod NUM_REQ, wrapping. Outputs one-hot winner and its index.
module rr_priority_picker
  import johnson_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IW-1:0]      o_idx,
  output logic               o_vld
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_vld    = 1'b0;
    w_cand   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand = IW'((int'(i_last) + off) % NUM_REQ);
      if (!o_vld && i_req[w_cand]) begin
        o_vld            = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/johnson_counter_scheduler.sv
// Round-robin scheduler sharing one Johnson timing resource among NUM_REQ
// requesters; issues start/stop pulses and per-requester done pulses.
module johnson_counter_scheduler
  import johnson_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH,
  parameter int JC_WIDTH  = DEF_JC_WIDTH
) (
  input  logic                           Clk_In,
  input  logic                           Reset_In,
  input  logic                           Enable_In,
  input  logic [NUM_REQ-1:0]             Req_In,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   Req_Length_In,
  input  logic                           Abort_In,
  output logic [NUM_REQ-1:0]             Grant_Out,
  output logic                           Busy_Out,
  output logic                           Start_Counter_Command_Out,
  output logic                           Stop_Counter_Command_Out,
  output logic [NUM_REQ-1:0]             Done_Out,
  output logic                           Aborted_Out,
  output logic [LEN_WIDTH-1:0]           Steps_Remaining_Out,
  output logic [JC_WIDTH-1:0]            Johnson_Count_Out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic [IW-1:0]        r_gidx;
  logic [IW-1:0]        r_last;
  logic                 r_busy;
  logic                 r_start;
  logic                 r_stop;
  logic                 r_aborted;
  logic [LEN_WIDTH-1:0] r_rem;
  logic [JC_WIDTH-1:0]  r_jc;

  logic [NUM_REQ-1:0]   w_win_onehot;
  logic [IW-1:0]        w_win_idx;
  logic                 w_win_vld;
  logic [LEN_WIDTH-1:0] w_win_len;
  logic [JC_WIDTH-1:0]  w_jc_next;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .i_req    (Req_In),
    .i_last   (r_last),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_vld    (w_win_vld)
  );

  assign w_win_len = Req_Length_In[int'(w_win_idx)*LEN_WIDTH +: LEN_WIDTH];
  assign w_jc_next = JC_WIDTH'(jc_next(JC_MAX'(r_jc), JC_WIDTH));

  // Falling-edge state machine; abort wins over completion on the same edge.
  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_done    <= '0;
      r_gidx    <= '0;
      r_last    <= IW'(NUM_REQ - 1);
      r_busy    <= 1'b0;
      r_start   <= 1'b0;
      r_stop    <= 1'b0;
      r_aborted <= 1'b0;
      r_rem     <= '0;
      r_jc      <= '0;
    end else begin
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Enable_In && w_win_vld) begin
            r_grant <= w_win_onehot;
            r_gidx  <= w_win_idx;
            r_rem   <= w_win_len;
            r_jc    <= '0;
            r_busy  <= 1'b1;
            if (w_win_len != '0) begin
              r_start <= 1'b1;
              r_state <= RUN;
            end else begin
              r_done  <= w_win_onehot;
              r_state <= DONE;
            end
          end
        end
        RUN: begin
          if (Abort_In) begin
            r_stop    <= 1'b1;
            r_aborted <= 1'b1;
            r_done    <= r_grant;
            r_state   <= DONE;
          end else if (Enable_In) begin
            r_jc  <= w_jc_next;
            r_rem <= r_rem - LEN_WIDTH'(1);
            if (r_rem == LEN_WIDTH'(1)) begin
              r_stop  <= 1'b1;
              r_done  <= r_grant;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_grant   <= '0;
          r_done    <= '0;
          r_aborted <= 1'b0;
          r_busy    <= 1'b0;
          r_last    <= r_gidx;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Grant_Out                 = r_grant;
  assign Busy_Out                  = r_busy;
  assign Start_Counter_Command_Out = r_start;
  assign Stop_Counter_Command_Out  = r_stop;
  assign Done_Out                  = r_done;
  assign Aborted_Out               = r_aborted;
  assign Steps_Remaining_Out       = r_rem;
  assign Johnson_Count_Out         = r_jc;

endmodule

// File: tb/tb_johnson_counter_scheduler.sv
// Scoreboard bench: stimulus pushes expected grant/done records, a monitor
// on the rising edge (DUT updates on the falling edge) pops and compares.
module tb_johnson_counter_scheduler;

  logic        Clk_In = 1'b0;
  logic        Reset_In;
  logic        Enable_In;
  logic [3:0]  Req_In;
  logic [31:0] Req_Length_In;
  logic        Abort_In;
  logic [3:0]  Grant_Out;
  logic        Busy_Out;
  logic        Start_Counter_Command_Out;
  logic        Stop_Counter_Command_Out;
  logic [3:0]  Done_Out;
  logic        Aborted_Out;
  logic [7:0]  Steps_Remaining_Out;
  logic [7:0]  Johnson_Count_Out;

  johnson_counter_scheduler #(.NUM_REQ(4), .LEN_WIDTH(8), .JC_WIDTH(8)) dut (
    .Clk_In                    (Clk_In),
    .Reset_In                  (Reset_In),
    .Enable_In                 (Enable_In),
    .Req_In                    (Req_In),
    .Req_Length_In             (Req_Length_In),
    .Abort_In                  (Abort_In),
    .Grant_Out                 (Grant_Out),
    .Busy_Out                  (Busy_Out),
    .Start_Counter_Command_Out (Start_Counter_Command_Out),
    .Stop_Counter_Command_Out  (Stop_Counter_Command_Out),
    .Done_Out                  (Done_Out),
    .Aborted_Out               (Aborted_Out),
    .Steps_Remaining_Out       (Steps_Remaining_Out),
    .Johnson_Count_Out         (Johnson_Count_Out)
  );

  always #5 Clk_In = ~Clk_In;

  typedef struct {
    logic [3:0] grant;
    logic [7:0] rem;
    logic       start;
    int         gap;
  } grant_rec_t;

  typedef struct {
    logic [3:0] done;
    logic       aborted;
    logic       stop;
    logic [7:0] rem;
    logic [7:0] jc;
    int         delta;
  } done_rec_t;

  grant_rec_t grant_q[$];
  done_rec_t  done_q[$];
  int cnt_cmp = 0;
  int cnt_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cnt_cmp++;
    if (act !== exp) begin
      cnt_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm);
    cnt_cmp++;
    cnt_bad++;
    $display("FAIL %s", nm);
  endtask

  task automatic push_grant(input logic [3:0] g, input logic [7:0] rem, input logic st, input int gap);
    grant_rec_t r;
    r.grant = g; r.rem = rem; r.start = st; r.gap = gap;
    grant_q.push_back(r);
  endtask

  task automatic push_done(input logic [3:0] d, input logic ab, input logic sp,
                           input logic [7:0] rem, input logic [7:0] jc, input int delta);
    done_rec_t r;
    r.done = d; r.aborted = ab; r.stop = sp; r.rem = rem; r.jc = jc; r.delta = delta;
    done_q.push_back(r);
  endtask

  // Monitor: grant rising edge and done pulses are the observable events.
  int         cyc = 0;
  int         grant_cyc = 0;
  int         last_grant_cyc = 0;
  logic [3:0] prev_grant = '0;

  always @(posedge Clk_In) begin
    grant_rec_t g;
    done_rec_t  d;
    cyc++;
    if (!Reset_In) begin
      if (Grant_Out != 4'b0 && prev_grant == 4'b0) begin
        if (grant_q.size() == 0) begin
          fail_evt("unexpected_grant");
        end else begin
          g = grant_q.pop_front();
          chk("grant_onehot", 32'(Grant_Out), 32'(g.grant));
          chk("grant_start", 32'(Start_Counter_Command_Out), 32'(g.start));
          chk("grant_rem", 32'(Steps_Remaining_Out), 32'(g.rem));
          chk("grant_jc", 32'(Johnson_Count_Out), 32'h0);
          if (g.gap >= 0) chk("grant_gap", 32'(cyc - last_grant_cyc), 32'(g.gap));
          last_grant_cyc = cyc;
          grant_cyc      = cyc;
        end
      end else if (Start_Counter_Command_Out) begin
        fail_evt("unexpected_start");
      end
      if (Done_Out != 4'b0) begin
        if (done_q.size() == 0) begin
          fail_evt("unexpected_done");
        end else begin
          d = done_q.pop_front();
          chk("done_onehot", 32'(Done_Out), 32'(d.done));
          chk("done_aborted", 32'(Aborted_Out), 32'(d.aborted));
          chk("done_stop", 32'(Stop_Counter_Command_Out), 32'(d.stop));
          chk("done_rem", 32'(Steps_Remaining_Out), 32'(d.rem));
          chk("done_jc", 32'(Johnson_Count_Out), 32'(d.jc));
          chk("done_latency", 32'(cyc - grant_cyc), 32'(d.delta));
        end
      end else if (Stop_Counter_Command_Out) begin
        fail_evt("unexpected_stop");
      end
    end
    prev_grant = Grant_Out;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk_In);
    #1;
  endtask

  task automatic wait_grant(input string nm);
    int n = 0;
    while (Grant_Out == 4'b0 && n < 100) begin
      tick(1);
      n++;
    end
    if (Grant_Out == 4'b0) fail_evt({nm, "_grant_timeout"});
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (Busy_Out && n < 200) begin
      tick(1);
      n++;
    end
    if (Busy_Out) fail_evt({nm, "_idle_timeout"});
  endtask

  task automatic set_len(input int i, input int v);
    Req_Length_In[i*8 +: 8] = 8'(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_In      = 1'b1;
    Enable_In     = 1'b0;
    Req_In        = 4'b0;
    Req_Length_In = '0;
    Abort_In      = 1'b0;
    tick(3);
    Reset_In = 1'b0;
    tick(1);
    chk("rst_grant", 32'(Grant_Out), 32'h0);
    chk("rst_busy", 32'(Busy_Out), 32'h0);
    chk("rst_rem", 32'(Steps_Remaining_Out), 32'h0);
    chk("rst_jc", 32'(Johnson_Count_Out), 32'h0);
    chk("rst_done", 32'(Done_Out), 32'h0);

    // Run of 3 on req0: jc 0 -> 01 -> 03 -> 07.
    set_len(0, 3);
    push_grant(4'b0001, 8'd3, 1'b1, -1);
    push_done(4'b0001, 1'b0, 1'b1, 8'd0, 8'h07, 3);
    Enable_In = 1'b1;
    Req_In    = 4'b0001;
    wait_grant("t1");
    Req_In = 4'b0;
    tick(1);
    chk("t1_k1_jc", 32'(Johnson_Count_Out), 32'h01);
    chk("t1_k1_rem", 32'(Steps_Remaining_Out), 32'd2);
    chk("t1_k1_busy", 32'(Busy_Out), 32'h1);
    tick(1);
    chk("t1_k2_jc", 32'(Johnson_Count_Out), 32'h03);
    chk("t1_k2_rem", 32'(Steps_Remaining_Out), 32'd1);
    tick(2);
    chk("t1_k4_grant", 32'(Grant_Out), 32'h0);
    chk("t1_k4_busy", 32'(Busy_Out), 32'h0);

    // All four requesting, length 2 each; last grant was req0.
    for (int i = 0; i < 4; i++) set_len(i, 2);
    push_grant(4'b0010, 8'd2, 1'b1, -1);
    push_grant(4'b0100, 8'd2, 1'b1, 4);
    push_grant(4'b1000, 8'd2, 1'b1, 4);
    push_grant(4'b0001, 8'd2, 1'b1, 4);
    push_grant(4'b0010, 8'd2, 1'b1, 4);
    for (int i = 0; i < 5; i++) push_done(4'b0000, 1'b0, 1'b1, 8'd0, 8'h03, 2);
    done_q[0].done = 4'b0010;
    done_q[1].done = 4'b0100;
    done_q[2].done = 4'b1000;
    done_q[3].done = 4'b0001;
    done_q[4].done = 4'b0010;
    Req_In = 4'b1111;
    tick(18);
    Req_In = 4'b0;
    wait_idle("t2");

    // Zero-length request: grant and done on the same edge, no start/stop.
    set_len(2, 0);
    push_grant(4'b0100, 8'd0, 1'b0, -1);
    push_done(4'b0100, 1'b0, 1'b0, 8'd0, 8'h00, 0);
    Req_In = 4'b0100;
    wait_grant("t3");
    Req_In = 4'b0;
    wait_idle("t3");

    // Length 20 with a 5-cycle pause; 20 shifts = 16 (wrap) + 4 -> 0F.
    set_len(3, 20);
    push_grant(4'b1000, 8'd20, 1'b1, -1);
    push_done(4'b1000, 1'b0, 1'b1, 8'd0, 8'h0F, 25);
    Req_In = 4'b1000;
    wait_grant("t4");
    Req_In = 4'b0;
    tick(5);
    chk("t4_pre_rem", 32'(Steps_Remaining_Out), 32'd15);
    chk("t4_pre_jc", 32'(Johnson_Count_Out), 32'h1F);
    Enable_In = 1'b0;
    tick(5);
    chk("t4_pause_rem", 32'(Steps_Remaining_Out), 32'd15);
    chk("t4_pause_jc", 32'(Johnson_Count_Out), 32'h1F);
    Enable_In = 1'b1;
    wait_idle("t4");

    // Abort at Rem=7, asserted together with Enable low.
    set_len(0, 10);
    push_grant(4'b0001, 8'd10, 1'b1, -1);
    push_done(4'b0001, 1'b1, 1'b1, 8'd7, 8'h07, 4);
    Req_In = 4'b0001;
    wait_grant("t5");
    Req_In = 4'b0;
    tick(3);
    chk("t5_rem7", 32'(Steps_Remaining_Out), 32'd7);
    Abort_In  = 1'b1;
    Enable_In = 1'b0;
    tick(1);
    Abort_In  = 1'b0;
    Enable_In = 1'b1;
    wait_idle("t5");

    // Short run on req1 so the pointer would favour req3 without a reset.
    set_len(1, 1);
    push_grant(4'b0010, 8'd1, 1'b1, -1);
    push_done(4'b0010, 1'b0, 1'b1, 8'd0, 8'h01, 1);
    Req_In = 4'b0010;
    wait_grant("t6a");
    Req_In = 4'b0;
    wait_idle("t6a");

    set_len(2, 6);
    push_grant(4'b0100, 8'd6, 1'b1, -1);
    Req_In = 4'b0100;
    wait_grant("t6b");
    Req_In = 4'b0;
    tick(2);
    chk("t6_rem4", 32'(Steps_Remaining_Out), 32'd4);
    #2 Reset_In = 1'b1;
    #1;
    chk("t6_rst_grant", 32'(Grant_Out), 32'h0);
    chk("t6_rst_busy", 32'(Busy_Out), 32'h0);
    chk("t6_rst_rem", 32'(Steps_Remaining_Out), 32'h0);
    chk("t6_rst_jc", 32'(Johnson_Count_Out), 32'h0);
    chk("t6_rst_start", 32'(Start_Counter_Command_Out), 32'h0);
    chk("t6_rst_stop", 32'(Stop_Counter_Command_Out), 32'h0);
    chk("t6_rst_done", 32'(Done_Out), 32'h0);
    chk("t6_rst_aborted", 32'(Aborted_Out), 32'h0);
    tick(2);
    Reset_In = 1'b0;

    set_len(1, 2);
    set_len(3, 2);
    push_grant(4'b0010, 8'd2, 1'b1, -1);
    push_done(4'b0010, 1'b0, 1'b1, 8'd0, 8'h03, 2);
    Req_In = 4'b1010;
    wait_grant("t6c");
    Req_In = 4'b0;
    wait_idle("t6c");
    tick(2);

    while (grant_q.size() > 0) begin
      void'(grant_q.pop_front());
      fail_evt("missing_grant");
    end
    while (done_q.size() > 0) begin
      void'(done_q.pop_front());
      fail_evt("missing_done");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_bad);
    $finish;
  end

endmodule
